// File: rtl/stall_pkg.sv
// Shared types for the pipeline stall/hazard controller.
package stall_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } br_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        MEM    = 2'd1,
        DATA   = 2'd2,
        BRANCH = 2'd3
    } stall_reason_t;

    // Branch shadow counter width; never narrower than one bit.
    function automatic int br_cnt_w(input int penalty);
        return (penalty < 2) ? 1 : $clog2(penalty + 1);
    endfunction

endpackage

// File: rtl/raw_match.sv
// One source-vs-destination RAW comparator; register 0 never matches.
module raw_match #(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            src_used,
    input  logic [RA_W-1:0] rd,
    input  logic            wr_en,
    output logic            match
);

    assign match = src_used & wr_en & (rd != '0) & (src == rd);

endmodule

// File: rtl/stall_ctrl.sv
// Stall/hazard controller for the 5-stage core: RAW hazards, branch shadow, memory wait.
// Build option: define STALL_FORWARD_EN when the forwarding network is present (load-use only).
module stall_ctrl
    import stall_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  ID_rs1,
    input  logic [RA_W-1:0]  ID_rs2,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic             ID_is_branch,
    input  logic [RA_W-1:0]  EX_rd,
    input  logic             EX_wr_en,
    input  logic             EX_is_load,
    input  logic [RA_W-1:0]  MEM_rd,
    input  logic             MEM_wr_en,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             ST_if_id_en,
    output logic             ST_id_ex_en,
    output logic             ST_ex_mem_en,
    output logic             ST_mem_wb_en,
    output logic             ST_id_ex_bubble,
    output logic             ST_br_stall,
    output logic [CNT_W-1:0] ST_stall_cnt
);

    localparam int              BC_W    = br_cnt_w(BR_PENALTY);
    localparam bit              MULTI   = (BR_PENALTY > 1);
    localparam logic [BC_W-1:0] BR_LOAD = BC_W'(BR_PENALTY - 1);

    logic                  mem_wait;
    logic                  hazard;
    logic [1:0][RA_W-1:0]  id_src;
    logic [1:0]            id_used;
    logic [1:0]            ex_hit;

    assign mem_wait = MEM_req & ~MEM_ready;
    assign id_src   = {ID_rs2, ID_rs1};
    assign id_used  = {ID_rs2_used, ID_rs1_used};

    for (genvar i = 0; i < 2; i++) begin : g_ex
        raw_match #(.RA_W(RA_W)) u_ex (
            .src      (id_src[i]),
            .src_used (id_used[i]),
            .rd       (EX_rd),
            .wr_en    (EX_wr_en),
            .match    (ex_hit[i])
        );
    end

`ifdef STALL_FORWARD_EN
    // Forwarding covers everything except a load whose data is not back yet.
    logic unused_mem;
    assign unused_mem = ^{MEM_rd, MEM_wr_en};
    assign hazard     = EX_is_load & (|ex_hit);
`else
    logic [1:0] mem_hit;
    logic       unused_ld;
    assign unused_ld = EX_is_load;

    for (genvar i = 0; i < 2; i++) begin : g_mem
        raw_match #(.RA_W(RA_W)) u_mem (
            .src      (id_src[i]),
            .src_used (id_used[i]),
            .rd       (MEM_rd),
            .wr_en    (MEM_wr_en),
            .match    (mem_hit[i])
        );
    end

    assign hazard = (|ex_hit) | (|mem_hit);
`endif

    br_state_t       state, state_nxt;
    logic [BC_W-1:0] bcnt, bcnt_nxt;
    logic            br_take;
    logic            br_raw;
    logic            br_q;
    stall_reason_t   reason;

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        br_take   = 1'b0;
        case (state)
            IDLE: begin
                // A branch stuck behind a data hazard waits in ID until the hazard clears.
                if (ID_is_branch && !hazard && !mem_wait) begin
                    br_take = 1'b1;
                    if (MULTI) begin
                        state_nxt = BR_WAIT;
                        bcnt_nxt  = BR_LOAD;
                    end
                end
            end
            BR_WAIT: begin
                if (!mem_wait) begin
                    if (bcnt == BC_W'(1)) state_nxt = IDLE;
                    bcnt_nxt = bcnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign br_raw = (state == BR_WAIT) | br_take;

    always_comb begin
        if (mem_wait)    reason = MEM;
        else if (hazard) reason = DATA;
        else if (br_raw) reason = BRANCH;
        else             reason = NONE;
    end

    always_comb begin
        ST_if_id_en     = 1'b0;
        ST_id_ex_en     = 1'b0;
        ST_ex_mem_en    = 1'b0;
        ST_mem_wb_en    = 1'b0;
        ST_id_ex_bubble = 1'b0;
        ST_br_stall     = 1'b0;
        // Outputs are forced low while reset is asserted, independent of the clock.
        if (rst) begin
            case (reason)
                MEM: begin
                    ST_br_stall = br_q;
                end
                DATA: begin
                    ST_id_ex_en     = 1'b1;
                    ST_ex_mem_en    = 1'b1;
                    ST_mem_wb_en    = 1'b1;
                    ST_id_ex_bubble = 1'b1;
                    ST_br_stall     = br_raw;
                end
                default: begin
                    ST_if_id_en  = 1'b1;
                    ST_id_ex_en  = 1'b1;
                    ST_ex_mem_en = 1'b1;
                    ST_mem_wb_en = 1'b1;
                    ST_br_stall  = br_raw;
                end
            endcase
        end
    end

    logic stall_any;
    assign stall_any = mem_wait | hazard | ST_br_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bcnt         <= '0;
            br_q         <= 1'b0;
            ST_stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            br_q  <= ST_br_stall;
            if (stall_any && !(&ST_stall_cnt))
                ST_stall_cnt <= ST_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized and directed bench for stall_ctrl; two instances (BR_PENALTY=3/CNT_W=16, BR_PENALTY=1/CNT_W=2).
module tb_stall_ctrl;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, br;
        logic [4:0] ex_rd;
        logic       ex_wr, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_wr, req, rdy;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] ID_rs1, ID_rs2, EX_rd, MEM_rd;
    logic       ID_rs1_used, ID_rs2_used, ID_is_branch;
    logic       EX_wr_en, EX_is_load, MEM_wr_en, MEM_req, MEM_ready;

    logic        a_if_id, a_id_ex, a_ex_mem, a_mem_wb, a_bub, a_br;
    logic        b_if_id, b_id_ex, b_ex_mem, b_mem_wb, b_bub, b_br;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    stall_ctrl #(.RA_W(5), .BR_PENALTY(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .ID_is_branch(ID_is_branch), .EX_rd(EX_rd), .EX_wr_en(EX_wr_en), .EX_is_load(EX_is_load),
        .MEM_rd(MEM_rd), .MEM_wr_en(MEM_wr_en), .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .ST_if_id_en(a_if_id), .ST_id_ex_en(a_id_ex), .ST_ex_mem_en(a_ex_mem), .ST_mem_wb_en(a_mem_wb),
        .ST_id_ex_bubble(a_bub), .ST_br_stall(a_br), .ST_stall_cnt(a_cnt)
    );

    stall_ctrl #(.RA_W(5), .BR_PENALTY(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .ID_is_branch(ID_is_branch), .EX_rd(EX_rd), .EX_wr_en(EX_wr_en), .EX_is_load(EX_is_load),
        .MEM_rd(MEM_rd), .MEM_wr_en(MEM_wr_en), .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .ST_if_id_en(b_if_id), .ST_id_ex_en(b_id_ex), .ST_ex_mem_en(b_ex_mem), .ST_mem_wb_en(b_mem_wb),
        .ST_id_ex_bubble(b_bub), .ST_br_stall(b_br), .ST_stall_cnt(b_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: remaining shadow cycles, last br_stall, stall count, per instance.
    int    pen[2]  = '{3, 1};
    int    cmax[2] = '{65535, 3};
    int    shadow[2];
    int    cnt[2];
    bit    prev_br[2];
    string otag[2] = '{"a_out", "b_out"};
    string ctag[2] = '{"a_cnt", "b_cnt"};

    logic [31:0] last_o[2];
    logic [31:0] last_c[2];
    int          nbr_a;

    function automatic bit hit(input stim_t s, input logic [4:0] rd, input logic en);
        return en && (rd != 5'd0) && ((s.u1 && s.rs1 == rd) || (s.u2 && s.rs2 == rd));
    endfunction

    function automatic bit hz(input stim_t s);
`ifdef STALL_FORWARD_EN
        return s.ex_ld && hit(s, s.ex_rd, s.ex_wr);
`else
        return hit(s, s.ex_rd, s.ex_wr) || hit(s, s.mem_rd, s.mem_wr);
`endif
    endfunction

    task automatic drive(input stim_t s);
        ID_rs1 = s.rs1;      ID_rs2 = s.rs2;
        ID_rs1_used = s.u1;  ID_rs2_used = s.u2;
        ID_is_branch = s.br;
        EX_rd = s.ex_rd;     EX_wr_en = s.ex_wr;  EX_is_load = s.ex_ld;
        MEM_rd = s.mem_rd;   MEM_wr_en = s.mem_wr;
        MEM_req = s.req;     MEM_ready = s.rdy;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        bit          mw, h, br;
        logic [31:0] exp_o;
        @(negedge clk);
        drive(s);
        #1;
        last_o[0] = 32'({a_if_id, a_id_ex, a_ex_mem, a_mem_wb, a_bub, a_br});
        last_o[1] = 32'({b_if_id, b_id_ex, b_ex_mem, b_mem_wb, b_bub, b_br});
        last_c[0] = 32'(a_cnt);
        last_c[1] = 32'(b_cnt);
        mw = s.req && !s.rdy;
        h  = hz(s);
        for (int k = 0; k < 2; k++) begin
            if (mw)                  br = prev_br[k];
            else if (shadow[k] > 0)  begin br = 1'b1; shadow[k]--; end
            else if (s.br && !h)     begin br = 1'b1; shadow[k] = pen[k] - 1; end
            else                     br = 1'b0;
            if (mw)     exp_o = 32'({5'b00000, br});
            else if (h) exp_o = 32'({5'b01111, br});
            else        exp_o = 32'({5'b11110, br});
            chk(otag[k], last_o[k], exp_o);
            chk(ctag[k], last_c[k], cnt[k]);
            if ((mw || h || br) && cnt[k] < cmax[k]) cnt[k]++;
            prev_br[k] = br;
        end
        if (last_o[0][0]) nbr_a++;
    endtask

    // Asynchronous reset from any point between edges; released on a falling edge with idle inputs.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        chk("rst_a_out", 32'({a_if_id, a_id_ex, a_ex_mem, a_mem_wb, a_bub, a_br}), 32'd0);
        chk("rst_b_out", 32'({b_if_id, b_id_ex, b_ex_mem, b_mem_wb, b_bub, b_br}), 32'd0);
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_b_cnt", 32'(b_cnt), 32'd0);
        for (int k = 0; k < 2; k++) begin
            shadow[k] = 0; cnt[k] = 0; prev_br[k] = 1'b0;
        end
        drive(idle());
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        stim_t s;
        drive(idle());
        apply_reset();

        // Load-use on rs1.
        s = idle(); s.ex_rd = 5'd5; s.ex_wr = 1'b1; s.ex_ld = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s);
        chk("t1_stall", last_o[0], 32'b011110);
        step(idle());
        chk("t1_clear", last_o[0], 32'b111100);
        chk("t1_cnt", last_c[0], 32'd1);

        // x0 never hazards; ALU result in MEM stalls only without forwarding.
        apply_reset();
        s = idle(); s.ex_rd = 5'd0; s.ex_wr = 1'b1; s.ex_ld = 1'b1; s.rs1 = 5'd0; s.u1 = 1'b1;
        step(s);
        chk("t2_x0", last_o[0], 32'b111100);
        s = idle(); s.mem_rd = 5'd7; s.mem_wr = 1'b1; s.rs2 = 5'd7; s.u2 = 1'b1;
        step(s);
`ifdef STALL_FORWARD_EN
        chk("t2_mem", last_o[0], 32'b111100);
`else
        chk("t2_mem", last_o[0], 32'b011110);
`endif

        // Branch shadow of three cycles.
        apply_reset();
        nbr_a = 0;
        s = idle(); s.br = 1'b1;
        step(s);
        repeat (4) step(idle());
        chk("t3_len", 32'(nbr_a), 32'd3);
        chk("t3_cnt", last_c[0], 32'd3);

        // Memory wait inside the shadow stretches it.
        apply_reset();
        nbr_a = 0;
        s = idle(); s.br = 1'b1;
        step(s);
        s = idle(); s.req = 1'b1; s.rdy = 1'b0;
        repeat (4) step(s);
        repeat (4) step(idle());
        chk("t4_len", 32'(nbr_a), 32'd7);

        // Reset asserted mid-shadow.
        apply_reset();
        s = idle(); s.br = 1'b1;
        step(s);
        step(idle());
        #2;
        apply_reset();
        step(idle());
        chk("t5_out", last_o[0], 32'b111100);
        chk("t5_cnt", last_c[0], 32'd0);

        // Stall counter saturation on the 2-bit instance.
        apply_reset();
        s = idle(); s.ex_rd = 5'd3; s.ex_wr = 1'b1; s.ex_ld = 1'b1; s.rs2 = 5'd3; s.u2 = 1'b1;
        repeat (5) step(s);
        step(idle());
        chk("t6_sat_b", last_c[1], 32'd3);
        chk("t6_cnt_a", last_c[0], 32'd5);

        // Randomized traffic with occasional asynchronous resets.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.u1     = 1'($urandom_range(0, 1));
            s.u2     = 1'($urandom_range(0, 1));
            s.br     = ($urandom_range(0, 3) == 0);
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.ex_wr  = 1'($urandom_range(0, 1));
            s.ex_ld  = 1'($urandom_range(0, 1));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.mem_wr = 1'($urandom_range(0, 1));
            s.req    = ($urandom_range(0, 2) == 0);
            s.rdy    = 1'($urandom_range(0, 1));
            step(s);
            if ($urandom_range(0, 63) == 0) begin
                #2;
                apply_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
